// File: rtl/dino_pkg.sv
// Shared definitions for the dino game: state encodings, playfield geometry,
// and a helper for sizing counters from their terminal counts.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_OVER  = 2'd2,
    ST_CRASH = 2'd3
  } game_state_t;

  localparam int PLAYFIELD_W = 32;
  localparam int LEVEL_MAX   = 7;

  // A count of 1 still needs one bit of storage.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for an active-low button plus a one-cycle pulse on
// the synchronized press (falling) edge; every flop resets to "released".
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      prev <= 1'b1;
    end else begin
      sync <= {sync[0], btn_n};
      prev <= sync[1];
    end
  end

  assign press = prev & ~sync[1];

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: IDLE/RUN/CRASH/OVER state machine, frame timebase, obstacle
// stepping/spawning and a difficulty ramp that shortens the step period.
module game_flow_ctrl
  import dino_pkg::*;
#(
  parameter int FRAME_DIV   = 833333,
  parameter int START_STEP  = 6,
  parameter int MIN_STEP    = 2,
  parameter int RAMP_FRAMES = 600,
  parameter int CRASH_HOLD  = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       jump_n,
  input  logic       collide,
  output logic [1:0] game_state,
  output logic [4:0] xcoor,
  output logic       obs_step,
  output logic       obs_spawn,
  output logic       score_en,
  output logic       clear_req,
  output logic [2:0] level,
  output logic       frame_tick
);

  localparam int FW = cnt_width(FRAME_DIV);
  localparam int RW = cnt_width(RAMP_FRAMES);
  localparam int HW = cnt_width(CRASH_HOLD);

  game_state_t state_q, state_d;

  logic [FW-1:0] frame_cnt;
  logic [RW-1:0] ramp_cnt;
  logic [HW-1:0] hold_cnt;
  logic [3:0]    step_cnt;
  logic [3:0]    step_period;
  logic          press;
  logic          step_due;
  logic          run_tick;
  logic          ramp_wrap;
  logic          hold_done;

  btn_edge_sync u_jump_sync (
    .clk   (clk),
    .rst   (rst),
    .btn_n (jump_n),
    .press (press)
  );

  assign frame_tick = (frame_cnt == FW'(FRAME_DIV - 1));
  assign step_due   = (step_cnt >= step_period - 4'd1);
  assign game_state = state_q;
  assign score_en   = (state_q == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A collision wins over any step, spawn or ramp that falls in the same cycle.
  always_comb begin
    state_d   = state_q;
    clear_req = 1'b0;
    obs_step  = 1'b0;
    obs_spawn = 1'b0;
    run_tick  = 1'b0;
    ramp_wrap = 1'b0;
    hold_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d   = ST_RUN;
          clear_req = 1'b1;
        end
      end
      ST_RUN: begin
        if (collide) begin
          state_d = ST_CRASH;
        end else if (frame_tick) begin
          run_tick  = 1'b1;
          obs_step  = step_due;
          obs_spawn = step_due && (xcoor == 5'(PLAYFIELD_W - 1));
          ramp_wrap = (ramp_cnt == RW'(RAMP_FRAMES - 1));
        end
      end
      ST_CRASH: begin
        if (frame_tick && (hold_cnt == HW'(CRASH_HOLD - 1))) begin
          hold_done = 1'b1;
          state_d   = ST_OVER;
        end
      end
      ST_OVER: begin
        if (press) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      ramp_cnt    <= '0;
      hold_cnt    <= '0;
      step_cnt    <= '0;
      step_period <= 4'(START_STEP);
      xcoor       <= '0;
      level       <= '0;
    end else begin
      frame_cnt <= frame_tick ? '0 : frame_cnt + FW'(1);

      if (clear_req) begin
        ramp_cnt    <= '0;
        step_cnt    <= '0;
        step_period <= 4'(START_STEP);
        xcoor       <= '0;
        level       <= '0;
      end else if (run_tick) begin
        // The step decision above already used the pre-ramp period.
        if (obs_step) begin
          step_cnt <= '0;
          xcoor    <= obs_spawn ? 5'd0 : xcoor + 5'd1;
        end else begin
          step_cnt <= step_cnt + 4'd1;
        end
        if (ramp_wrap) begin
          ramp_cnt <= '0;
          if (step_period > 4'(MIN_STEP)) step_period <= step_period - 4'd1;
          if (level < 3'(LEVEL_MAX))      level       <= level + 3'd1;
        end else begin
          ramp_cnt <= ramp_cnt + RW'(1);
        end
      end

      if ((state_q != ST_CRASH) || hold_done) hold_cnt <= '0;
      else if (frame_tick)                    hold_cnt <= hold_cnt + HW'(1);
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Randomized bench for game_flow_ctrl: a behavioural game model predicts output
// events into a scoreboard queue that an independent monitor drains and checks.
module tb_game_flow_ctrl;

  localparam int FD = 4;
  localparam int SS = 3;
  localparam int MS = 1;
  localparam int RF = 8;
  localparam int CH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       jump_n;
  logic       collide;
  logic [1:0] game_state;
  logic [4:0] xcoor;
  logic       obs_step;
  logic       obs_spawn;
  logic       score_en;
  logic       clear_req;
  logic [2:0] level;
  logic       frame_tick;

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .FRAME_DIV   (FD),
    .START_STEP  (SS),
    .MIN_STEP    (MS),
    .RAMP_FRAMES (RF),
    .CRASH_HOLD  (CH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .jump_n     (jump_n),
    .collide    (collide),
    .game_state (game_state),
    .xcoor      (xcoor),
    .obs_step   (obs_step),
    .obs_spawn  (obs_spawn),
    .score_en   (score_en),
    .clear_req  (clear_req),
    .level      (level),
    .frame_tick (frame_tick)
  );

  typedef struct {
    int step;
    int spawn;
    int clear;
    int tick;
    int gstate;
    int x;
    int lvl;
    int score;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   mon_last = 0;

  // Game model: 0 idle, 1 run, 2 over, 3 crash; counters hold elapsed frames.
  int m_state, m_x, m_level, m_period, m_step, m_ramp, m_hold, m_frame, m_last;
  bit jn_age1, jn_age2, jn_age3;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_x = 0; m_level = 0; m_period = SS;
    m_step = 0; m_ramp = 0; m_hold = 0; m_frame = 0; m_last = 0;
    jn_age1 = 1'b1; jn_age2 = 1'b1; jn_age3 = 1'b1;
  endtask

  // Predict what the DUT shows during this cycle, then advance across the edge.
  task automatic model_eval(input bit jn, input bit col);
    bit   ft, press, step, spawn, clear;
    exp_t e;
    ft    = (m_frame == FD - 1);
    press = jn_age3 && !jn_age2;
    clear = (m_state == 0) && press;
    step  = (m_state == 1) && !col && ft && (m_step + 1 >= m_period);
    spawn = step && (m_x == 31);
    if (step || clear || ft || (m_state != m_last)) begin
      e.step = int'(step); e.spawn = int'(spawn); e.clear = int'(clear);
      e.tick = int'(ft); e.gstate = m_state; e.x = m_x; e.lvl = m_level;
      e.score = (m_state == 1) ? 1 : 0;
      sb.push_back(e);
      m_last = m_state;
    end
    case (m_state)
      0: if (press) begin
        m_state = 1; m_x = 0; m_level = 0; m_period = SS; m_step = 0; m_ramp = 0;
      end
      1: if (col) begin
        m_state = 3; m_hold = 0;
      end else if (ft) begin
        if (step) begin m_step = 0; m_x = (m_x + 1) % 32; end
        else m_step++;
        m_ramp++;
        if (m_ramp == RF) begin
          m_ramp = 0;
          if (m_period - 1 >= MS) m_period--;
          if (m_level + 1 <= 7) m_level++;
        end
      end
      3: if (ft) begin
        m_hold++;
        if (m_hold == CH) begin m_state = 2; m_hold = 0; end
      end
      2: if (press) m_state = 0;
      default: m_state = 0;
    endcase
    m_frame = (m_frame + 1) % FD;
    jn_age3 = jn_age2; jn_age2 = jn_age1; jn_age1 = jn;
  endtask

  task automatic apply_stimulus(input bit jn, input bit col);
    jump_n  = jn;
    collide = col;
    model_eval(jn, col);
    @(posedge clk);
    #1;
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input int hold_cycles);
    #2;
    rst    = 1'b1;
    mon_en = 1'b0;
    #1;
    check_output("rst_state", int'(game_state), 0);
    check_output("rst_xcoor", int'(xcoor), 0);
    check_output("rst_level", int'(level), 0);
    check_output("rst_score_en", int'(score_en), 0);
    check_output("rst_obs_step", int'(obs_step), 0);
    check_output("rst_obs_spawn", int'(obs_spawn), 0);
    check_output("rst_clear_req", int'(clear_req), 0);
    check_output("rst_frame_tick", int'(frame_tick), 0);
    repeat (hold_cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    model_reset();
    mon_last = 0;
    mon_en   = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && (obs_step || clear_req || frame_tick || (int'(game_state) != mon_last))) begin
      mon_last = int'(game_state);
      if (sb.size() == 0) begin
        check_output("unexpected_event", 1, 0);
      end else begin
        e = sb.pop_front();
        check_output("obs_step", int'(obs_step), e.step);
        check_output("obs_spawn", int'(obs_spawn), e.spawn);
        check_output("clear_req", int'(clear_req), e.clear);
        check_output("frame_tick", int'(frame_tick), e.tick);
        check_output("game_state", int'(game_state), e.gstate);
        check_output("xcoor", int'(xcoor), e.x);
        check_output("level", int'(level), e.lvl);
        check_output("score_en", int'(score_en), e.score);
      end
    end
  end

  initial begin
    int n;
    int saved_x;
    bit reset_done;
    rst = 1'b0; jump_n = 1'b1; collide = 1'b0;
    #1;
    async_reset(3);

    repeat (100) apply_stimulus(1'b1, 1'b0);
    check_output("idle_state", int'(game_state), 0);

    repeat (20) apply_stimulus(1'b0, 1'b0);
    repeat (4) apply_stimulus(1'b1, 1'b0);
    check_output("started_run", int'(game_state), 1);

    for (int i = 0; i < 700; i++) apply_stimulus(1'($urandom_range(0, 1)), 1'b0);
    check_output("level_saturated", int'(level), 7);

    n = 0;
    while (!((m_frame == FD - 1) && (m_step + 1 >= m_period)) && n < 50) begin
      apply_stimulus(1'b1, 1'b0);
      n++;
    end
    if (n >= 50) check_output("wait_step_due", 0, 1);
    saved_x = int'(xcoor);
    apply_stimulus(1'b1, 1'b1);
    check_output("crash_state", int'(game_state), 3);
    check_output("crash_xcoor", int'(xcoor), saved_x);
    repeat (3) apply_stimulus(1'b0, 1'b0);
    n = 0;
    while (m_state != 2 && n < 40) begin
      apply_stimulus(1'b1, 1'b0);
      n++;
    end
    if (n >= 40) check_output("wait_over", 0, 1);
    check_output("over_state", int'(game_state), 2);

    repeat (4) apply_stimulus(1'b0, 1'b0);
    repeat (4) apply_stimulus(1'b1, 1'b0);
    check_output("back_idle", int'(game_state), 0);
    check_output("idle_keeps_xcoor", int'(xcoor), saved_x);
    repeat (4) apply_stimulus(1'b0, 1'b0);
    check_output("rerun_state", int'(game_state), 1);
    check_output("rerun_xcoor", int'(xcoor), 0);
    check_output("rerun_level", int'(level), 0);
    repeat (4) apply_stimulus(1'b1, 1'b0);

    reset_done = 1'b0;
    for (int r = 0; r < 3000; r++) begin
      if (!reset_done && r >= 1500 && m_state == 1) begin
        async_reset(2);
        reset_done = 1'b1;
      end
      apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end
    if (!reset_done) check_output("mid_run_reset_reached", 0, 1);

    @(negedge clk);
    #1;
    check_output("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
